// File: rtl/norm_shift_pipe.sv
// rtl/norm_shift_pipe.sv - two-stage normalize / logical / arithmetic shift pipeline
//
// Purpose: accepts one operand per cycle and either normalizes it left
// (shift out leading zeros, report the count) or shifts it right logically
// or arithmetically, reporting the bits lost as a sticky flag. A sideband
// tag travels with each operation unchanged.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake
//   din             operand
//   mode            00 normalize-left, 01 SRL, 10 SRA, 11 treated as SRL
//   shamt_in        right-shift amount (ignored when normalizing)
//   in_tag          sideband tag
//   out_valid/ready output handshake
//   dout            shifted result
//   out_shamt       shift actually applied
//   out_zero        dout == 0
//   out_sticky      OR of bits shifted out (right modes only)
//   out_tag         tag of the operation being presented
module norm_shift_pipe #(
   parameter int DWIDTH = 32,
   parameter int SWIDTH = $clog2(DWIDTH),
   parameter int TWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] din,
   input  logic [1:0]        mode,
   input  logic [SWIDTH:0]   shamt_in,
   input  logic [TWIDTH-1:0] in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] dout,
   output logic [SWIDTH:0]   out_shamt,
   output logic              out_zero,
   output logic              out_sticky,
   output logic [TWIDTH-1:0] out_tag
);

   localparam logic [SWIDTH:0]   ONE_AMT = (SWIDTH+1)'(1);
   localparam logic [SWIDTH:0]   DW_AMT  = (SWIDTH+1)'(DWIDTH);
   localparam logic [DWIDTH-1:0] ONES    = '1;

   // ---------------- handshake ----------------
   logic s1_valid, s2_valid;
   logic s1_load, s1_advance, s2_load;

   assign s2_load    = ~s2_valid | out_ready;
   assign s1_advance = s1_valid & s2_load;
   // Gated by rst so nothing is accepted while the pipe is held in reset.
   assign in_ready   = ~rst & (~s1_valid | s1_advance);
   assign s1_load    = in_valid & in_ready;

   // ---------------- leading-zero count tree ----------------
   // Level 0 holds one node per bit; each level merges pairs of nodes. A node
   // covering 2^l bits carries "all zero" and its leading-zero count. When the
   // upper half is all zero the count is 2^l plus the lower half's count; the
   // lower count is < 2^l so the addition is a simple OR.
   logic [SWIDTH:0] lz_cnt  [0:SWIDTH][0:DWIDTH-1];
   logic            lz_zero [0:SWIDTH][0:DWIDTH-1];
   logic [SWIDTH:0] lz_count;

   always_comb begin
      for (int l = 0; l <= SWIDTH; l++) begin
         for (int i = 0; i < DWIDTH; i++) begin
            lz_cnt[l][i]  = '0;
            lz_zero[l][i] = 1'b0;
         end
      end
      for (int i = 0; i < DWIDTH; i++) begin
         lz_zero[0][i] = ~din[i];
      end
      for (int l = 0; l < SWIDTH; l++) begin
         for (int j = 0; j < (DWIDTH >> (l + 1)); j++) begin
            if (lz_zero[l][2*j+1]) begin
               lz_cnt[l+1][j] = lz_cnt[l][2*j] | (ONE_AMT << l);
            end else begin
               lz_cnt[l+1][j] = lz_cnt[l][2*j+1];
            end
            lz_zero[l+1][j] = lz_zero[l][2*j+1] & lz_zero[l][2*j];
         end
      end
      // A zero operand normalizes with no shift at all.
      lz_count = lz_zero[SWIDTH][0] ? '0 : lz_cnt[SWIDTH][0];
   end

   // ---------------- stage 1 registers ----------------
   logic [DWIDTH-1:0] s1_data;
   logic              s1_right;
   logic              s1_arith;
   logic [SWIDTH:0]   s1_shamt;
   logic [TWIDTH-1:0] s1_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_right <= 1'b0;
         s1_arith <= 1'b0;
         s1_shamt <= '0;
         s1_tag   <= '0;
      end else begin
         s1_valid <= s1_load | (s1_valid & ~s1_advance);
         if (s1_load) begin
            s1_data  <= din;
            s1_right <= (mode != 2'b00);
            s1_arith <= (mode == 2'b10);
            s1_shamt <= (mode == 2'b00) ? lz_count : shamt_in;
            s1_tag   <= in_tag;
         end
      end
   end

   // ---------------- barrel shift ----------------
   logic [DWIDTH-1:0] sh_dout;
   logic              sh_sticky;
   logic              fill;

   always_comb begin
      sh_dout   = '0;
      sh_sticky = 1'b0;
      fill      = s1_arith & s1_data[DWIDTH-1];
      if (!s1_right) begin
         sh_dout = s1_data << s1_shamt;
      end else if (s1_shamt >= DW_AMT) begin
         sh_dout   = {DWIDTH{fill}};
         sh_sticky = |s1_data;
      end else begin
         // Vacated upper positions take the fill bit; lost low bits feed sticky.
         sh_dout   = (s1_data >> s1_shamt) | (fill ? ~(ONES >> s1_shamt) : '0);
         sh_sticky = |(s1_data & ~(ONES << s1_shamt));
      end
   end

   // ---------------- stage 2 registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         dout       <= '0;
         out_shamt  <= '0;
         out_zero   <= 1'b0;
         out_sticky <= 1'b0;
         out_tag    <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            dout       <= sh_dout;
            out_shamt  <= s1_shamt;
            out_zero   <= (sh_dout == '0);
            out_sticky <= sh_sticky;
            out_tag    <= s1_tag;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb/tb_norm_shift_pipe.sv - self-checking bench for norm_shift_pipe
module tb_norm_shift_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] din = '0;
   logic [1:0]  mode = '0;
   logic [5:0]  shamt_in = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] dout;
   logic [5:0]  out_shamt;
   logic        out_zero;
   logic        out_sticky;
   logic [3:0]  out_tag;

   norm_shift_pipe #(.DWIDTH(32), .TWIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .mode(mode), .shamt_in(shamt_in), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .out_shamt(out_shamt), .out_zero(out_zero),
      .out_sticky(out_sticky), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: straight from the arithmetic definition of each mode.
   typedef struct packed {
      logic [31:0] dout;
      logic [5:0]  shamt;
      logic        zero;
      logic        sticky;
   } res_t;

   function automatic res_t model(input logic [31:0] d, input logic [1:0] m, input logic [5:0] s);
      res_t r;
      int n;
      logic arith;
      r = '0;
      if (m == 2'b00) begin
         n = 0;
         if (d != 0) while (d[31-n] == 1'b0) n++;
         r.dout   = d << n;
         r.shamt  = 6'(n);
         r.sticky = 1'b0;
      end else begin
         arith   = (m == 2'b10);
         r.shamt = s;
         if (s >= 6'd32) begin
            r.dout   = (arith && d[31]) ? 32'hFFFF_FFFF : 32'h0;
            r.sticky = (d != 0);
         end else begin
            r.dout   = arith ? 32'($signed(d) >>> s) : (d >> s);
            r.sticky = (s == 0) ? 1'b0 : ((d & ((32'd1 << s) - 32'd1)) != 0);
         end
      end
      r.zero = (r.dout == 0);
      return r;
   endfunction

   // Scoreboard monitor for the randomized phase. Transfers are judged at the
   // falling edge and take effect on the following rising edge.
   typedef struct packed {
      res_t       res;
      logic [3:0] tag;
   } exp_t;

   exp_t exp_q[$];
   logic mon_en = 1'b0;
   logic held = 1'b0;
   logic [43:0] held_val;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (held && out_valid)
            chk("hold_stable", {dout, out_shamt, out_zero, out_sticky, out_tag}, held_val);
         held     = out_valid && !out_ready;
         held_val = {dout, out_shamt, out_zero, out_sticky, out_tag};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               chk("rand_result", {dout, out_shamt, out_zero, out_sticky, out_tag}, exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back({model(din, mode, shamt_in), in_tag});
      end
   end

   typedef struct {
      logic [31:0] din;
      logic [1:0]  mode;
      logic [5:0]  shamt;
      logic [3:0]  tag;
      logic [31:0] e_dout;
      logic [5:0]  e_shamt;
      logic        e_zero;
      logic        e_sticky;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  got_tags[$];
      logic [31:0] got_data[$];
      logic [31:0] cap;
      logic        acc;
      int          seen;

      vecs[0]  = '{32'h0000_1234, 2'b00, 6'd0,  4'h1, 32'h91A0_0000, 6'd19, 1'b0, 1'b0};
      vecs[1]  = '{32'h0000_0000, 2'b00, 6'd7,  4'h2, 32'h0000_0000, 6'd0,  1'b1, 1'b0};
      vecs[2]  = '{32'h8000_0010, 2'b10, 6'd5,  4'h3, 32'hFC00_0000, 6'd5,  1'b0, 1'b1};
      vecs[3]  = '{32'hDEAD_BEEF, 2'b01, 6'd40, 4'h4, 32'h0000_0000, 6'd40, 1'b1, 1'b1};
      vecs[4]  = '{32'hDEAD_BEEF, 2'b01, 6'd0,  4'h5, 32'hDEAD_BEEF, 6'd0,  1'b0, 1'b0};
      vecs[5]  = '{32'hF000_0001, 2'b11, 6'd4,  4'h6, 32'h0F00_0000, 6'd4,  1'b0, 1'b1};
      vecs[6]  = '{32'h8000_0000, 2'b10, 6'd32, 4'h7, 32'hFFFF_FFFF, 6'd32, 1'b0, 1'b1};
      vecs[7]  = '{32'h4000_0000, 2'b10, 6'd63, 4'h8, 32'h0000_0000, 6'd63, 1'b1, 1'b1};
      vecs[8]  = '{32'h0000_0001, 2'b00, 6'd3,  4'h9, 32'h8000_0000, 6'd31, 1'b0, 1'b0};
      vecs[9]  = '{32'h0000_0001, 2'b01, 6'd1,  4'hA, 32'h0000_0000, 6'd1,  1'b1, 1'b1};
      vecs[10] = '{32'h7FFF_FFF0, 2'b10, 6'd4,  4'hB, 32'h07FF_FFFF, 6'd4,  1'b0, 1'b0};
      vecs[11] = '{32'hFFFF_FFFF, 2'b00, 6'd9,  4'hC, 32'hFFFF_FFFF, 6'd0,  1'b0, 1'b0};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_outputs", {dout, out_shamt, out_zero, out_sticky, out_tag}, 64'd0);
      chk("rst_no_accept", 64'(in_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // ---- table vectors, fixed two-cycle latency ----
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; din = vecs[i].din; mode = vecs[i].mode;
         shamt_in = vecs[i].shamt; in_tag = vecs[i].tag;
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_lat1", i), 64'(out_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_lat2", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_result", i),
             {dout, out_shamt, out_zero, out_sticky, out_tag},
             {vecs[i].e_dout, vecs[i].e_shamt, vecs[i].e_zero, vecs[i].e_sticky, vecs[i].tag});
      end
      @(posedge clk); #1;

      // ---- three back-to-back with stalled output ----
      out_ready = 1'b0;
      mode = 2'b01; shamt_in = 6'd0;
      in_valid = 1'b1; din = 32'h11; in_tag = 4'd1;
      @(negedge clk);
      chk("bb_accept1", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      din = 32'h22; in_tag = 4'd2;
      @(negedge clk);
      chk("bb_accept2", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      din = 32'h33; in_tag = 4'd3;
      @(negedge clk);
      chk("bb_full_ready", 64'(in_ready), 64'd0);
      chk("bb_head", {out_valid, out_tag, dout}, {1'b1, 4'd1, 32'h11});
      cap = dout;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bb_stall", {in_ready, out_valid, out_tag, dout}, {1'b0, 1'b1, 4'd1, cap});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got_tags.size() < 3; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid) begin
            got_tags.push_back(out_tag);
            got_data.push_back(dout);
         end
         @(posedge clk); #1;
         if (acc) in_valid = 1'b0;
      end
      chk("bb_count", 64'(got_tags.size()), 64'd3);
      if (got_tags.size() == 3) begin
         chk("bb_order", {got_tags[0], got_tags[1], got_tags[2]}, {4'd1, 4'd2, 4'd3});
         chk("bb_data", {got_data[0], got_data[1], got_data[2]}, {32'h11, 32'h22, 32'h33});
      end
      in_valid = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("bb_no_dup", 64'(seen), 64'd0);

      // ---- reset while full ----
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; din = 32'h55; in_tag = 4'd5;
      @(posedge clk); #1;
      din = 32'h66; in_tag = 4'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mr_full", {out_valid, out_tag}, {1'b1, 4'd5});
      #1 rst = 1'b1;
      #1;
      chk("mr_async_clear", {out_valid, dout, out_shamt, out_zero, out_sticky, out_tag}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("mr_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mr_discard", 64'(seen), 64'd0);

      // ---- randomized traffic against the model ----
      mon_en = 1'b1;
      repeat (2000) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         din       = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) din = din | 32'h8000_0000;
         mode      = 2'($urandom_range(0, 3));
         shamt_in  = 6'($urandom_range(0, 63));
         in_tag    = 4'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
